// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: memory-side responder for the LC3 memory bus.
// The array is word-addressed. An accepted access waits WAIT_CYCLES cycles
// and then answers with a one-cycle complete pulse.
// Read data appears on dout no later than complete.
// A write commits on the edge that raises complete.
module lc3_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        complete,
    output logic        busy
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [3:0]          cnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [15:0]         data_r;
    logic                op_rd_r;
    logic [15:0]         dout_r;
    logic                complete_r;
    logic                busy_r;
    logic [15:0]         mem [0:DEPTH-1];

    logic                accept_s;
    logic                rd_op_s;
    logic [ADDR_W-1:0]   rd_idx_s;
    logic                read_en_s;
    logic                write_en_s;

    // Upper address bits alias onto the array and are deliberately dropped.
    generate
        if (ADDR_W < 16) begin : g_alias
            logic addr_hi_unused_s;
            assign addr_hi_unused_s = ^addr[15:ADDR_W];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, a single RESP cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rd || wr) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state_s = ST_RESP;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output/control decode. A zero-wait read resolves on the accept edge,
    // so the read address and op come straight from the bus in that case.
    always_comb begin
        accept_s   = 1'b0;
        rd_op_s    = op_rd_r;
        rd_idx_s   = addr_r;
        read_en_s  = 1'b0;
        write_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s = rd || wr;
                rd_op_s  = rd;
                rd_idx_s = addr[ADDR_W-1:0];
            end
            ST_WAIT: begin
                accept_s = 1'b0;
            end
            ST_RESP: begin
                write_en_s = !op_rd_r;
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
        if (next_state_s == ST_RESP) begin
            read_en_s = rd_op_s;
        end else begin
            read_en_s = 1'b0;
        end
    end

    // Request latch and wait-state counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r  <= '0;
            data_r  <= 16'h0000;
            op_rd_r <= 1'b0;
            cnt_r   <= 4'd0;
        end else if (accept_s) begin
            addr_r  <= addr[ADDR_W-1:0];
            data_r  <= din;
            op_rd_r <= rd;
            cnt_r   <= WAIT_INIT;
        end else if (state_r == ST_WAIT) begin
            cnt_r   <= cnt_r - 4'd1;
        end else begin
            cnt_r   <= cnt_r;
        end
    end

    // Registered outputs: complete follows the RESP cycle, busy tracks the in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_r     <= 16'h0000;
            complete_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            complete_r <= (state_r == ST_RESP);
            busy_r     <= (next_state_s != ST_IDLE);
            if (read_en_s) begin
                dout_r <= mem[rd_idx_s];
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    // Storage array: not reset. A write commits on the edge leaving RESP.
    always_ff @(posedge clk) begin
        if (write_en_s) begin
            mem[addr_r] <= data_r;
        end
    end

    assign dout     = dout_r;
    assign complete = complete_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder. It builds one instance with
// WAIT_CYCLES=2 and one with WAIT_CYCLES=0. Each instance has a plain array
// model that tracks memory contents and the last value read.
module tb_lc3_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd2 = 1'b0, wr2 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
    logic [15:0] addr2 = 16'h0000, din2 = 16'h0000, addr0 = 16'h0000, din0 = 16'h0000;
    logic [15:0] dout2, dout0;
    logic        complete2, complete0, busy2, busy0;

    bit          sel0 = 1'b0;
    wire  [15:0] dout_m     = sel0 ? dout0 : dout2;
    wire         complete_m = sel0 ? complete0 : complete2;
    wire         busy_m     = sel0 ? busy0 : busy2;

    int          checks = 0;
    int          errors = 0;

    logic [15:0] model [2][256];
    logic [15:0] last_d [2];

    always #5 clk = ~clk;

    lc3_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .rd(rd2), .wr(wr2), .addr(addr2), .din(din2),
        .dout(dout2), .complete(complete2), .busy(busy2)
    );

    lc3_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .rd(rd0), .wr(wr0), .addr(addr0), .din(din0),
        .dout(dout0), .complete(complete0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit s, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d);
        if (s) begin
            rd0 = r; wr0 = w; addr0 = a; din0 = d;
        end else begin
            rd2 = r; wr2 = w; addr2 = a; din2 = d;
        end
    endtask

    // One complete access. Inputs are held until complete is seen. The task
    // checks latency, busy, dout, and the return to idle. When chg is set,
    // the address changes to na during the wait.
    task automatic access(input bit s, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d,
                          input bit chg, input logic [15:0] na);
        int          wc;
        int          lat;
        int          si;
        logic [15:0] exp_d;
        si    = s ? 1 : 0;
        wc    = s ? 0 : 2;
        sel0  = s;
        lat   = -1;
        exp_d = r ? model[si][a[7:0]] : last_d[si];
        @(negedge clk);
        set_in(s, r, w, a, d);
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0 && chg) begin
                set_in(s, r, w, na, d);
            end
            if (complete_m === 1'b1) begin
                lat = k;
                break;
            end
            if (k <= wc) begin
                check("busy_during_access", {31'd0, busy_m}, 32'd1);
            end
        end
        check("latency", lat, wc + 1);
        check("dout_at_complete", {16'd0, dout_m}, {16'd0, exp_d});
        set_in(s, 1'b0, 1'b0, a, d);
        if (r) begin
            last_d[si] = exp_d;
        end else begin
            model[si][a[7:0]] = d;
        end
        @(negedge clk);
        check("complete_pulse_ends", {31'd0, complete_m}, 32'd0);
        check("busy_clears", {31'd0, busy_m}, 32'd0);
    endtask

    initial begin
        bit          s;
        int          op;
        logic [7:0]  idx;
        logic [15:0] a;
        logic [15:0] v;
        logic [15:0] old20;

        last_d[0] = 16'h0000;
        last_d[1] = 16'h0000;

        // Reset then idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_w2", {15'd0, dout2, complete2, busy2}, 32'd0);
            check("idle_w0", {15'd0, dout0, complete0, busy0}, 32'd0);
        end

        // Write then read with two wait states.
        access(1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000);
        access(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000);

        // Preload low words of both instances, plus 0x20 on the wait-state one.
        for (int i = 0; i < 16; i++) begin
            v = {8'(i), 8'($urandom)};
            access(1'b0, 1'b0, 1'b1, 16'(i), v, 1'b0, 16'h0000);
            access(1'b1, 1'b0, 1'b1, 16'(i), v ^ 16'h0F0F, 1'b0, 16'h0000);
        end
        access(1'b0, 1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0000);

        // Zero wait states: single read, then held rd gives a pulse every 2 cycles.
        access(1'b1, 1'b0, 1'b1, 16'h0003, 16'h1234, 1'b0, 16'h0000);
        access(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'h0000);
        sel0 = 1'b1;
        @(negedge clk);
        set_in(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000);
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("b2b_complete", {31'd0, complete0}, {31'd0, 1'(k % 2)});
            if (k % 2 == 1) begin
                check("b2b_dout", {16'd0, dout0}, 32'h0000_1234);
            end
            if (k == 7) begin
                set_in(1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000);
            end
        end
        last_d[1] = 16'h1234;
        repeat (2) @(negedge clk);

        // Aliasing, then rd and wr both high.
        access(1'b0, 1'b0, 1'b1, 16'h0105, 16'hA5A5, 1'b0, 16'h0000);
        access(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h0000);
        check("alias_model", {16'd0, last_d[0]}, 32'h0000_A5A5);
        access(1'b0, 1'b1, 1'b1, 16'h0005, 16'h0000, 1'b0, 16'h0000);
        access(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h0000);

        // Reset during the wait of a write: no complete, no commit.
        old20 = model[0][8'h20];
        sel0  = 1'b0;
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b1, 16'h0020, 16'h7777);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_complete", {31'd0, complete2}, 32'd0);
        check("rst_mid_busy", {31'd0, busy2}, 32'd0);
        check("rst_mid_dout", {16'd0, dout2}, 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        last_d[0] = 16'h0000;
        last_d[1] = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rst_no_complete", {31'd0, complete2}, 32'd0);
        end
        access(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000);
        check("rst_no_commit", {16'd0, last_d[0]}, {16'd0, old20});

        // During the wait, the address changes. Only the latched address counts.
        access(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'h0002);

        // Randomized accesses on both instances, with aliased upper bytes.
        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom_range(0, 1));
            idx = 8'($urandom_range(0, 15));
            a   = {8'($urandom), idx};
            op  = $urandom_range(0, 2);
            access(s, op != 1, op != 0, a, 16'($urandom), 1'b0, 16'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
